// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for a 32x32 RGB LED panel: fetches pixel pairs, shifts them out,
// latches each row pair and holds it lit for HOLD_CYCLES clocks.
module matrix_scan_ctrl #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int HOLD_CYCLES = 256
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   en,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   rd_addr,
    input  logic [2:0]                             rd_data1,
    input  logic [2:0]                             rd_data2,
    output logic [2:0]                             RGB1,
    output logic [2:0]                             RGB2,
    output logic                                   freq1,
    output logic                                   LAT,
    output logic                                   OE,
    output logic [$clog2(ROWS)-1:0]                rowD,
    output logic                                   frame_done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CLK,
        S_BLANK,
        S_LATCH,
        S_HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [HW-1:0]   hold_cnt, hold_cnt_nxt;

    logic [RW+CW-1:0] rd_addr_nxt;
    logic [2:0]       rgb1_nxt, rgb2_nxt;
    logic             freq1_nxt, lat_nxt, oe_nxt, frame_done_nxt;
    logic [RW-1:0]    rowd_nxt;

    always_comb begin
        state_nxt      = state;
        row_nxt        = row;
        col_nxt        = col;
        hold_cnt_nxt   = hold_cnt;
        rd_addr_nxt    = rd_addr;
        rgb1_nxt       = RGB1;
        rgb2_nxt       = RGB2;
        freq1_nxt      = freq1;
        lat_nxt        = 1'b0;
        oe_nxt         = OE;
        rowd_nxt       = rowD;
        frame_done_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                oe_nxt    = 1'b1;
                freq1_nxt = 1'b0;
                if (en)
                    state_nxt = S_ADDR;
            end
            S_ADDR: begin
                rd_addr_nxt = {row, col};
                freq1_nxt   = 1'b0;
                state_nxt   = S_DATA;
            end
            S_DATA: begin
                rgb1_nxt  = rd_data1;
                rgb2_nxt  = rd_data2;
                state_nxt = S_CLK;
            end
            S_CLK: begin
                freq1_nxt = 1'b1;
                if (col == COL_LAST) begin
                    col_nxt   = '0;
                    state_nxt = S_BLANK;
                end else begin
                    col_nxt   = col + 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_BLANK: begin
                freq1_nxt = 1'b0;
                oe_nxt    = 1'b1;
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                lat_nxt   = 1'b1;
                rowd_nxt  = row;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // OE stays low on the exit edge; IDLE raises it one clock later,
                // so a final row is lit for exactly HOLD_CYCLES clocks.
                oe_nxt = 1'b0;
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt_nxt   = '0;
                    row_nxt        = (row == ROW_LAST) ? '0 : row + 1'b1;
                    frame_done_nxt = (row == ROW_LAST);
                    state_nxt      = en ? S_ADDR : S_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            hold_cnt   <= '0;
            rd_addr    <= '0;
            RGB1       <= '0;
            RGB2       <= '0;
            freq1      <= 1'b0;
            LAT        <= 1'b0;
            OE         <= 1'b1;
            rowD       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            hold_cnt   <= hold_cnt_nxt;
            rd_addr    <= rd_addr_nxt;
            RGB1       <= rgb1_nxt;
            RGB2       <= rgb2_nxt;
            freq1      <= freq1_nxt;
            LAT        <= lat_nxt;
            OE         <= oe_nxt;
            rowD       <= rowd_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: directed vector table, timing sequences, and a
// randomized run checked every clock against an arithmetic scan-timeline model.
module tb_matrix_scan_ctrl;

    localparam int COLS   = 32;
    localparam int ROWS   = 16;
    localparam int HOLD   = 256;
    localparam int SHIFT  = 3 * COLS;
    localparam int ROWLEN = SHIFT + 2 + HOLD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [8:0] rd_addr;
    logic [2:0] rd_data1, rd_data2, RGB1, RGB2;
    logic       freq1, LAT, OE, frame_done;
    logic [3:0] rowD;

    logic [2:0] mem1 [512];
    logic [2:0] mem2 [512];

    assign rd_data1 = mem1[rd_addr];
    assign rd_data2 = mem2[rd_addr];

    always #5 clk = ~clk;

    matrix_scan_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rd_addr    (rd_addr),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .RGB1       (RGB1),
        .RGB2       (RGB2),
        .freq1      (freq1),
        .LAT        (LAT),
        .OE         (OE),
        .rowD       (rowD),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [8:0] addr;
        logic [2:0] rgb1;
        logic [2:0] rgb2;
        logic       f1;
        logic       lat;
        logic       oe;
        logic [3:0] rowd;
        logic       fd;
    } out_t;

    typedef struct {
        int   cyc;
        logic rst;
        logic en;
        out_t exp;
    } vec_t;

    out_t got;
    assign got = {rd_addr, RGB1, RGB2, freq1, LAT, OE, rowD, frame_done};

    int checks = 0;
    int failures = 0;

    function automatic out_t mk(int a, int r1, int r2, int f, int l, int o, int rd, int fd);
        out_t x;
        x.addr = 9'(a);
        x.rgb1 = 3'(r1);
        x.rgb2 = 3'(r2);
        x.f1   = 1'(f);
        x.lat  = 1'(l);
        x.oe   = 1'(o);
        x.rowd = 4'(rd);
        x.fd   = 1'(fd);
        return x;
    endfunction

    task automatic check_out(string name, out_t a, out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s @%0t: got addr=%0d rgb1=%0d rgb2=%0d f1=%0b lat=%0b oe=%0b rowd=%0d fd=%0b; expected addr=%0d rgb1=%0d rgb2=%0d f1=%0b lat=%0b oe=%0b rowd=%0d fd=%0b",
                     name, $time, a.addr, a.rgb1, a.rgb2, a.f1, a.lat, a.oe, a.rowd, a.fd,
                     e.addr, e.rgb1, e.rgb2, e.f1, e.lat, e.oe, e.rowd, e.fd);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs after edge t of a scan run (edge 0 = the IDLE edge that saw en),
    // derived from the row timeline: 3 clk per column, blank, latch, hold.
    function automatic out_t exp_at(int t, int r0, logic [2:0] pr1, logic [2:0] pr2, logic [3:0] prd);
        out_t x;
        int r, p, row, prow, c, c2;
        r    = (t - 1) / ROWLEN;
        p    = (t - 1) % ROWLEN;
        row  = (r0 + r) % ROWS;
        prow = (r0 + r + ROWS - 1) % ROWS;
        c    = (p < SHIFT) ? p / 3 : COLS - 1;
        x.addr = 9'(row * COLS + c);
        if (p == 0) begin
            if (r > 0) begin
                x.rgb1 = mem1[9'(prow * COLS + COLS - 1)];
                x.rgb2 = mem2[9'(prow * COLS + COLS - 1)];
            end else begin
                x.rgb1 = pr1;
                x.rgb2 = pr2;
            end
        end else begin
            c2 = (p < SHIFT) ? (p - 1) / 3 : COLS - 1;
            x.rgb1 = mem1[9'(row * COLS + c2)];
            x.rgb2 = mem2[9'(row * COLS + c2)];
        end
        x.f1   = (p < SHIFT) && (p % 3 == 2);
        x.lat  = (p == SHIFT + 1);
        x.oe   = (p < SHIFT) ? (r == 0) : (p <= SHIFT + 1);
        x.rowd = (p >= SHIFT + 1) ? 4'(row) : ((r > 0) ? 4'(prow) : prd);
        x.fd   = (p == ROWLEN - 1) && (row == ROWS - 1);
        return x;
    endfunction

    // Reference model + protocol checker, active on every clock.
    logic       m_valid = 1'b0, m_run = 1'b0, m_rs, m_es;
    int         m_t, m_r0, m_row;
    out_t       e, prev_got;
    logic [2:0] p_rgb1, p_rgb2;
    logic [3:0] p_rowd;

    always begin
        @(posedge clk);
        m_rs = reset;
        m_es = en;
        if (!m_rs) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_row   = 0;
            e       = mk(0, 0, 0, 0, 0, 1, 0, 0);
        end else if (m_valid) begin
            if (!m_run) begin
                e.f1  = 1'b0;
                e.lat = 1'b0;
                e.fd  = 1'b0;
                e.oe  = 1'b1;
                if (m_es) begin
                    m_run  = 1'b1;
                    m_t    = 0;
                    m_r0   = m_row;
                    p_rgb1 = e.rgb1;
                    p_rgb2 = e.rgb2;
                    p_rowd = e.rowd;
                end
            end else begin
                m_t++;
                e = exp_at(m_t, m_r0, p_rgb1, p_rgb2, p_rowd);
                if (((m_t - 1) % ROWLEN == ROWLEN - 1) && !m_es) begin
                    m_run = 1'b0;
                    m_row = (m_r0 + (m_t - 1) / ROWLEN + 1) % ROWS;
                end
            end
        end
        #1;
        if (m_valid) begin
            check_out("model", got, e);
            if (got.lat || got.f1)
                check_val("lat_f1_excl", int'(got.lat & got.f1), 0);
            if (got.lat) begin
                check_val("oe_during_lat", int'(got.oe), 1);
                check_val("oe_before_lat", int'(prev_got.oe), 1);
            end
            if (m_rs && got.f1)
                check_val("rgb_setup", int'({got.rgb1, got.rgb2}), int'({prev_got.rgb1, prev_got.rgb2}));
            if (m_rs && prev_got.f1)
                check_val("rgb_hold", int'({got.rgb1, got.rgb2}), int'({prev_got.rgb1, prev_got.rgb2}));
        end
        prev_got = got;
    end

    vec_t tbl [21];

    initial begin
        int k, lat_t, oe_low, lat_n, fd_n, fd_t;
        logic pf1;

        // Directed vectors; cumulative edge count t is from the go edge of each run.
        tbl[0]  = '{3,   1'b0, 1'b1, mk(0,   0, 0, 0, 0, 1, 0, 0)};
        tbl[1]  = '{1,   1'b1, 1'b1, mk(0,   0, 0, 0, 0, 1, 0, 0)};
        tbl[2]  = '{1,   1'b1, 1'b1, mk(0,   0, 0, 0, 0, 1, 0, 0)};
        tbl[3]  = '{2,   1'b1, 1'b1, mk(0,   0, 7, 1, 0, 1, 0, 0)};
        tbl[4]  = '{30,  1'b1, 1'b1, mk(10,  2, 5, 1, 0, 1, 0, 0)};
        tbl[5]  = '{64,  1'b1, 1'b1, mk(31,  7, 0, 0, 0, 1, 0, 0)};
        tbl[6]  = '{1,   1'b1, 1'b1, mk(31,  7, 0, 0, 1, 1, 0, 0)};
        tbl[7]  = '{1,   1'b1, 1'b1, mk(31,  7, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{255, 1'b1, 1'b1, mk(31,  7, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{1,   1'b1, 1'b1, mk(32,  7, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{738, 1'b1, 1'b1, mk(106, 1, 6, 0, 0, 0, 2, 0)};
        tbl[11] = '{1,   1'b1, 1'b0, mk(106, 2, 5, 0, 0, 0, 2, 0)};
        tbl[12] = '{322, 1'b1, 1'b0, mk(127, 7, 0, 0, 0, 0, 3, 0)};
        tbl[13] = '{1,   1'b1, 1'b0, mk(127, 7, 0, 0, 0, 1, 3, 0)};
        tbl[14] = '{5,   1'b1, 1'b0, mk(127, 7, 0, 0, 0, 1, 3, 0)};
        tbl[15] = '{1,   1'b1, 1'b1, mk(127, 7, 0, 0, 0, 1, 3, 0)};
        tbl[16] = '{1,   1'b1, 1'b1, mk(128, 7, 0, 0, 0, 1, 3, 0)};
        tbl[17] = '{414, 1'b1, 1'b1, mk(180, 3, 4, 0, 0, 0, 4, 0)};
        tbl[18] = '{1,   1'b0, 1'b1, mk(0,   0, 0, 0, 0, 1, 0, 0)};
        tbl[19] = '{1,   1'b1, 1'b1, mk(0,   0, 0, 0, 0, 1, 0, 0)};
        tbl[20] = '{1,   1'b1, 1'b1, mk(0,   0, 0, 0, 0, 1, 0, 0)};

        for (int a = 0; a < 512; a++) begin
            mem1[a] = 3'(a);
            mem2[a] = ~3'(a);
        end

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            en    = tbl[i].en;
            repeat (tbl[i].cyc) @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Single row: en seen only at the go edge, so exactly one row runs.
        @(negedge clk); reset = 1'b0; en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; en = 1'b1;
        @(posedge clk);
        @(negedge clk); en = 1'b0;
        k = 0; lat_t = -1; oe_low = 0; pf1 = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk); #1;
            if (freq1 && !pf1) begin
                check_val("T2_rgb1_edge", int'(RGB1), k % 8);
                check_val("T2_rgb2_edge", int'(RGB2), 7 - (k % 8));
                k++;
            end
            if (LAT) begin
                lat_t = t;
                check_val("T2_lat_rowd", int'(rowD), 0);
            end
            if (OE == 1'b0) oe_low++;
            pf1 = freq1;
        end
        check_val("T2_edges", k, 32);
        check_val("T2_lat_clk", lat_t, 98);
        check_val("T2_oe_low", oe_low, 256);
        check_val("T2_oe_idle", int'(OE), 1);

        // Full frame: row order, address row field, frame_done timing and wrap.
        @(negedge clk); reset = 1'b0; en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        lat_n = 0; fd_n = 0; fd_t = -1;
        for (int t = 1; t <= ROWS * ROWLEN + 120; t++) begin
            @(posedge clk); #1;
            if (LAT) begin
                check_val("T3_rowd", int'(rowD), lat_n % ROWS);
                check_val("T3_addr_row", int'(rd_addr[8:5]), lat_n % ROWS);
                lat_n++;
            end
            if (frame_done) begin
                fd_n++;
                fd_t = t;
            end
        end
        check_val("T3_fd_count", fd_n, 1);
        check_val("T3_fd_time", fd_t, ROWS * ROWLEN);
        check_val("T3_lat_count", lat_n, ROWS + 1);

        // Randomized content, en toggling and occasional reset; model checks each clock.
        @(negedge clk); reset = 1'b0; en = 1'b0;
        for (int a = 0; a < 512; a++) begin
            mem1[a] = 3'($urandom);
            mem2[a] = 3'($urandom);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; en = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            reset = 1'b1;
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 2999) == 0) reset = 1'b0;
        end
        @(posedge clk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
